// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes are queued in a FIFO and sent 8N1, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data (8E1 frames).
module uart_tx_fifo #(
    parameter int  CLKS_PER_BIT = 25,
    parameter int  FIFO_DEPTH   = 16,
    localparam int ADDR_W       = $clog2(FIFO_DEPTH)
) (
    input  logic            i_Clock,
    input  logic            i_Rst_L,
    input  logic            i_Wr_DV,
    input  logic [7:0]      i_Wr_Byte,
    output logic            o_Full,
    output logic            o_Empty,
    output logic [ADDR_W:0] o_Count,
    output logic            o_Overflow,
    output logic            o_TX_Active,
    output logic            o_TX_Serial,
    output logic            o_TX_Done
);
    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_next;
    logic              wr_en, rd_en;

    state_t           state, state_next;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic             serial_next, done_next, last_cnt;
`ifdef UART_TX_PARITY_EN
    logic             parity, parity_next;
`endif

    // A full FIFO drops the write even when a pop frees a slot in the same cycle.
    assign wr_en    = i_Wr_DV && !o_Full;
    assign last_cnt = (bit_cnt == LAST_CNT);

    // NOTE: storage has no reset; pointers and count alone define valid contents.
    always_ff @(posedge i_Clock) begin
        if (wr_en) mem[wr_ptr] <= i_Wr_Byte;
    end

    always_comb begin
        unique case ({wr_en, rd_en})
            2'b10:   count_next = o_Count + 1'b1;
            2'b01:   count_next = o_Count - 1'b1;
            default: count_next = o_Count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Count    <= '0;
            o_Full     <= 1'b0;
            o_Empty    <= 1'b1;
            o_Overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            o_Count <= count_next;
            o_Full  <= (count_next == DEPTH_CNT);
            o_Empty <= (count_next == '0);
            if (i_Wr_DV && o_Full) o_Overflow <= 1'b1;
        end
    end

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        rd_en        = 1'b0;
        done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity;
`endif
        unique case (state)
            S_IDLE: begin
                if (!o_Empty) begin
                    rd_en        = 1'b1;
                    shift_next   = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                    parity_next  = ^mem[rd_ptr];
`endif
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = S_START;
                end
            end
            S_START: begin
                bit_cnt_next = bit_cnt + 1'b1;
                if (last_cnt) begin
                    bit_cnt_next = '0;
                    state_next   = S_DATA;
                end
            end
            S_DATA: begin
                bit_cnt_next = bit_cnt + 1'b1;
                if (last_cnt) begin
                    bit_cnt_next = '0;
                    shift_next   = shift >> 1;
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                bit_cnt_next = bit_cnt + 1'b1;
                if (last_cnt) begin
                    bit_cnt_next = '0;
                    state_next   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                bit_cnt_next = bit_cnt + 1'b1;
                if (last_cnt) begin
                    bit_cnt_next = '0;
                    done_next    = 1'b1;
                    state_next   = S_IDLE;
                    // Chain straight into the next start bit when more data is queued.
                    if (!o_Empty) begin
                        rd_en        = 1'b1;
                        shift_next   = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_next  = ^mem[rd_ptr];
`endif
                        bit_idx_next = '0;
                        state_next   = S_START;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The line is registered from the next state so it changes in step with the FSM.
    always_comb begin
        unique case (state_next)
            S_START: serial_next = 1'b0;
            S_DATA:  serial_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: serial_next = parity_next;
`endif
            default: serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            bit_idx     <= bit_idx_next;
            shift       <= shift_next;
            o_TX_Serial <= serial_next;
            o_TX_Active <= (state_next != S_IDLE);
            o_TX_Done   <= done_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) parity <= 1'b0;
        else          parity <= parity_next;
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo: a depth-16 and a depth-4 instance, both at 4 clocks per bit.
module tb_uart_tx_fifo;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FR = NB * CPB;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       wr_dv   = 1'b0;
    logic [7:0] wr_byte = 8'h00;
    logic       sel     = 1'b0;

    logic       wr_a, full_a, empty_a, ovf_a, active_a, serial_a, done_a;
    logic [4:0] count_a;
    logic       wr_b, full_b, empty_b, ovf_b, active_b, serial_b, done_b;
    logic [2:0] count_b;

    logic       obs_serial, obs_active, obs_done, obs_full, obs_empty, obs_ovf;
    logic [4:0] obs_count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    assign wr_a = wr_dv & ~sel;
    assign wr_b = wr_dv & sel;

    assign obs_serial = sel ? serial_b : serial_a;
    assign obs_active = sel ? active_b : active_a;
    assign obs_done   = sel ? done_b   : done_a;
    assign obs_full   = sel ? full_b   : full_a;
    assign obs_empty  = sel ? empty_b  : empty_a;
    assign obs_ovf    = sel ? ovf_b    : ovf_a;
    assign obs_count  = sel ? {2'b00, count_b} : count_a;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut_a (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr_a), .i_Wr_Byte(wr_byte),
        .o_Full(full_a), .o_Empty(empty_a), .o_Count(count_a), .o_Overflow(ovf_a),
        .o_TX_Active(active_a), .o_TX_Serial(serial_a), .o_TX_Done(done_a)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut_b (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr_b), .i_Wr_Byte(wr_byte),
        .o_Full(full_b), .o_Empty(empty_b), .o_Count(count_b), .o_Overflow(ovf_b),
        .o_TX_Active(active_b), .o_TX_Serial(serial_b), .o_TX_Done(done_b)
    );

    function automatic logic [7:0] stream_byte(input int k);
        return 8'((k * 29) + 7);
    endfunction

    // Samples one whole frame, starting at the first start-bit cycle.
    task automatic check_frame(input logic [7:0] exp, input logic done_first);
        logic [NB-1:0] bits;
        logic          exp_done;
`ifdef UART_TX_PARITY_EN
        bits = {1'b1, ^exp, exp, 1'b0};
`else
        bits = {1'b1, exp, 1'b0};
`endif
        for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            exp_done = (i == 0) && done_first;
            vectors++;
            if (obs_serial !== bits[i / CPB] || obs_active !== 1'b1 || obs_done !== exp_done) begin
                errors++;
                $display("FAIL frame byte=%02h sample=%0d: serial/active/done got %b%b%b want %b1%b",
                         exp, i, obs_serial, obs_active, obs_done, bits[i / CPB], exp_done);
            end
        end
    endtask

    task automatic check_idle_after();
        @(negedge clk);
        vectors++;
        if ({obs_serial, obs_active, obs_done} !== 3'b101) begin
            errors++;
            $display("FAIL done_pulse: serial/active/done got %b%b%b want 101", obs_serial, obs_active, obs_done);
        end
        @(negedge clk);
        vectors++;
        if ({obs_serial, obs_active, obs_done} !== 3'b100) begin
            errors++;
            $display("FAIL after_done: serial/active/done got %b%b%b want 100", obs_serial, obs_active, obs_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({serial_a, active_a, done_a, empty_a, full_a, ovf_a} !== 6'b100100 || count_a !== 5'd0) begin
            errors++;
            $display("FAIL reset_a: flags %b count %0d, want 100100 count 0",
                     {serial_a, active_a, done_a, empty_a, full_a, ovf_a}, count_a);
        end
        vectors++;
        if ({serial_b, active_b, done_b, empty_b, full_b, ovf_b} !== 6'b100100 || count_b !== 3'd0) begin
            errors++;
            $display("FAIL reset_b: flags %b count %0d, want 100100 count 0",
                     {serial_b, active_b, done_b, empty_b, full_b, ovf_b}, count_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic send_one(input logic [7:0] b);
        wr_dv   = 1'b1;
        wr_byte = b;
        @(negedge clk);
        wr_dv = 1'b0;
        vectors++;
        if (obs_empty !== 1'b0 || obs_count !== 5'd1 || obs_serial !== 1'b1 || obs_active !== 1'b0) begin
            errors++;
            $display("FAIL write_latency: empty/count/serial/active got %b/%0d/%b/%b want 0/1/1/0",
                     obs_empty, obs_count, obs_serial, obs_active);
        end
        check_frame(b, 1'b0);
        check_idle_after();
    endtask

    task automatic test_single();
        sel = 1'b0;
        send_one(8'hA5);
        vectors++;
        if (obs_empty !== 1'b1 || obs_count !== 5'd0) begin
            errors++;
            $display("FAIL single_drained: empty/count got %b/%0d want 1/0", obs_empty, obs_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'h01, 8'h02, 8'h03};
        sel = 1'b0;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    wr_dv   = 1'b1;
                    wr_byte = bytes[k];
                    @(negedge clk);
                end
                wr_dv = 1'b0;
            end
            begin
                @(negedge clk);
                for (int k = 0; k < 3; k++) check_frame(bytes[k], k != 0);
                check_idle_after();
            end
        join
    endtask

    task automatic test_overflow();
        logic [7:0] ov [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        sel = 1'b1;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    wr_dv   = 1'b1;
                    wr_byte = ov[k];
                    @(negedge clk);
                    if (k == 3) begin
                        vectors++;
                        if (obs_full !== 1'b0 || obs_count !== 5'd3) begin
                            errors++;
                            $display("FAIL ovf_before_full: full/count got %b/%0d want 0/3", obs_full, obs_count);
                        end
                    end
                    if (k == 4) begin
                        vectors++;
                        if (obs_full !== 1'b1 || obs_count !== 5'd4 || obs_ovf !== 1'b0) begin
                            errors++;
                            $display("FAIL ovf_full: full/count/ovf got %b/%0d/%b want 1/4/0", obs_full, obs_count, obs_ovf);
                        end
                    end
                end
                wr_dv = 1'b0;
                vectors++;
                if (obs_ovf !== 1'b1 || obs_full !== 1'b1 || obs_count !== 5'd4) begin
                    errors++;
                    $display("FAIL ovf_drop: ovf/full/count got %b/%b/%0d want 1/1/4", obs_ovf, obs_full, obs_count);
                end
            end
            begin
                @(negedge clk);
                for (int k = 0; k < 5; k++) check_frame(ov[k], k != 0);
                check_idle_after();
                vectors++;
                if (obs_ovf !== 1'b1 || obs_empty !== 1'b1 || obs_count !== 5'd0) begin
                    errors++;
                    $display("FAIL ovf_sticky: ovf/empty/count got %b/%b/%0d want 1/1/0", obs_ovf, obs_empty, obs_count);
                end
            end
        join
        sel = 1'b0;
    endtask

    task automatic test_stream_wrap();
        sel = 1'b0;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    wr_dv   = 1'b1;
                    wr_byte = stream_byte(k);
                    @(negedge clk);
                end
                wr_dv = 1'b0;
                vectors++;
                if (obs_count !== 5'd2) begin
                    errors++;
                    $display("FAIL stream_prefill: count got %0d want 2", obs_count);
                end
                // Each later write lands on the last stop cycle, coinciding with a pop.
                for (int j = 0; j < 19; j++) begin
                    repeat ((j == 0) ? FR - 2 : FR - 1) @(negedge clk);
                    wr_dv   = 1'b1;
                    wr_byte = stream_byte(j + 3);
                    @(negedge clk);
                    wr_dv = 1'b0;
                    vectors++;
                    if (obs_count !== 5'd2) begin
                        errors++;
                        $display("FAIL push_pop_count j=%0d: count got %0d want 2", j, obs_count);
                    end
                end
            end
            begin
                @(negedge clk);
                for (int k = 0; k < 22; k++) check_frame(stream_byte(k), k != 0);
                check_idle_after();
            end
        join
    endtask

    task automatic test_mid_reset();
        sel = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr_dv   = 1'b1;
            wr_byte = 8'hC0 + 8'(k);
            @(negedge clk);
        end
        wr_dv = 1'b0;
        repeat (6) @(negedge clk);
        vectors++;
        if (count_a !== 5'd3 || active_a !== 1'b1 || ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: count_a/active_a/ovf_b got %0d/%b/%b want 3/1/1", count_a, active_a, ovf_b);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({serial_a, active_a, done_a, empty_a, full_a, ovf_a} !== 6'b100100 || count_a !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset_a: flags %b count %0d, want 100100 count 0",
                     {serial_a, active_a, done_a, empty_a, full_a, ovf_a}, count_a);
        end
        vectors++;
        if (ovf_b !== 1'b0 || empty_b !== 1'b1 || count_b !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_b: ovf/empty/count got %b/%b/%0d want 0/1/0", ovf_b, empty_b, count_b);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vectors++;
            if (serial_a !== 1'b1 || active_a !== 1'b0 || empty_a !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_idle cycle=%0d: serial/active/empty got %b/%b/%b want 1/0/1",
                         i, serial_a, active_a, empty_a);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        sel = 1'b0;
        send_one(8'h07);
        send_one(8'h03);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_stream_wrap();
        test_mid_reset();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter: fabric logic pushes bytes into an internal FIFO, and the block serialises them 8N1, LSB first, on o_TX_Serial. It is the transmit-side counterpart to the UART byte receiver. It lets a producer issue bursts without waiting per byte, and drives the TX pin directly: the line idles high and needs no external mux.

Parameters:
CLKS_PER_BIT, 25, clock cycles per UART bit (integer >= 2).
FIFO_DEPTH, 16, FIFO entries (power of 2, >= 2); ADDR_W = $clog2(FIFO_DEPTH).

Ports:
i_Clock  input  1  system clock; all logic on rising edge.
i_Rst_L  input  1  synchronous, active-low reset.
i_Wr_DV  input  1  write strobe; one byte per cycle when high.
i_Wr_Byte  input  8  byte to enqueue; sampled when i_Wr_DV=1.
o_Full  output  1  FIFO holds FIFO_DEPTH bytes.
o_Empty  output  1  FIFO holds 0 bytes.
o_Count  output  ADDR_W+1  bytes currently in FIFO (excludes byte in serializer).
o_Overflow  output  1  sticky; set when a write is dropped.
o_TX_Active  output  1  high while a frame is on the line.
o_TX_Serial  output  1  UART line; 1 when idle.
o_TX_Done  output  1  1-cycle pulse at end of each frame.

Behaviour:
- Reset (i_Rst_L=0 at a clock edge): FIFO emptied, o_Empty=1, o_Full=0, o_Count=0, o_Overflow=0, o_TX_Active=0, o_TX_Serial=1, o_TX_Done=0, FSM=IDLE. Mid-frame reset aborts the frame; the line returns high on the next cycle.
- All outputs are registered.
- FIFO write: accepted when i_Wr_DV=1 and o_Full=0 (registered value). A write while o_Full=1 is dropped and sets o_Overflow, even if a pop occurs in the same cycle.
- Simultaneous accepted write and pop: o_Count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. A bit counter counts 0..CLKS_PER_BIT-1; a bit index counts 0..7.
- IDLE: o_TX_Serial=1, o_TX_Active=0. If FIFO is non-empty: pop the head into the shift register and go to START.
- START: o_TX_Serial=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: o_TX_Serial=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit; after bit 7, go to STOP.
- STOP: o_TX_Serial=1 for CLKS_PER_BIT cycles. o_TX_Done=1 on the cycle after the last stop cycle.
  - If the FIFO is non-empty at the last stop cycle, pop and go directly to START: no idle gap, and o_TX_Active stays 1.
  - Otherwise go to IDLE.
- Latency: write at cycle N into an empty FIFO with FSM in IDLE gives o_Empty=0 at N+1, pop at N+1, first start-bit cycle on o_TX_Serial at N+2.
- o_TX_Active is 1 from the first start-bit cycle through the last stop-bit cycle.
- Frame length is 10*CLKS_PER_BIT cycles (11* with parity).

Optional Feature:
UART_TX_PARITY_EN:
- Defined: a PARITY state between DATA and STOP drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 8E1, 11 bits.
- Undefined: no parity state; frame is 8N1, 10 bits.

Test Plan:
- Reset with FIFO holding 3 bytes and the FSM mid-DATA -> next cycle o_TX_Serial=1, o_Count=0, o_Empty=1, o_Overflow=0.
- CLKS_PER_BIT=4, write 0xA5 once -> start bit at N+2, then line bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles, o_TX_Done pulse, o_TX_Active low after.
- Write 0x01,0x02,0x03 on consecutive cycles -> three frames back-to-back with no idle gap, o_TX_Active high for 30*CLKS_PER_BIT cycles, three o_TX_Done pulses.
- FIFO_DEPTH=4, write 6 bytes in 6 cycles (first popped at N+1) -> o_Full=1 after 5th, 6th dropped, o_Overflow=1 and stays 1; 5 frames sent with correct data.
- With o_Count=2, write and pop in the same cycle -> o_Count stays 2; ordering of output bytes preserved across pointer wrap (20+ bytes streamed through depth 16).
- UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame 11*CLKS_PER_BIT cycles.
